// File: rtl/alu_share_arbiter_pkg.sv
// alu_arb_pkg: opcode constants, opcode class and arbiter state encodings
package alu_arb_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_NOP   = 7'b0000000;
  typedef enum logic [1:0] {LDST, ARITH, ILLEGAL} opc_class_t;
  typedef enum logic [1:0] {IDLE, ALU_REQ, ACK_UP, ALU_REL} state_t;
endpackage

// File: rtl/alu_share_arbiter_dec.sv
// opcode_class_dec: maps a 7-bit opcode to its class
//   i_opcode [6:0]  opcode to classify
//   o_class  [1:0]  LDST, ARITH or ILLEGAL (opc_class_t encoding)
module opcode_class_dec
  import alu_arb_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [1:0] o_class
);
  opc_class_t w_class;
  always_comb
    w_class = (i_opcode == OP_LOAD || i_opcode == OP_STORE) ? LDST :
              (i_opcode == OP_REG || i_opcode == OP_IMM || i_opcode == OP_NOP) ? ARITH : ILLEGAL;
  assign o_class = w_class;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin four-phase arbiter sharing one ALU between two ports
//   clk, rst                 clock, async active-high reset
//   i_req_1/i_opcode_1       port 1 (load/store) request and opcode, o_ack_1 acknowledge
//   i_req_2/i_opcode_2       port 2 (arithmetic) request and opcode, o_ack_2 acknowledge
//   o_alu_req/i_alu_ack      four-phase handshake with the shared ALU
//   o_alu_sel/o_alu_op       granted port (0 = port 1) and its opcode, held for the transaction
//   o_opc_err/o_timeout_err  sticky error flags
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_1,
  input  logic [6:0] i_opcode_1,
  output logic       o_ack_1,
  input  logic       i_req_2,
  input  logic [6:0] i_opcode_2,
  output logic       o_ack_2,
  output logic       o_alu_req,
  input  logic       i_alu_ack,
  output logic       o_alu_sel,
  output logic [6:0] o_alu_op,
  output logic       o_opc_err,
  output logic       o_timeout_err
);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_rr;
  logic       r_ack_1, r_ack_2, r_alu_req, r_sel, r_opc_err, r_timeout_err;
  logic [6:0] r_op;
  logic [1:0] w_cls_1, w_cls_2;
  logic       w_el_1, w_el_2, w_g2, w_greq, w_tmo;

  opcode_class_dec u_dec_1 (.i_opcode(i_opcode_1), .o_class(w_cls_1));
  opcode_class_dec u_dec_2 (.i_opcode(i_opcode_2), .o_class(w_cls_2));

  assign w_el_1 = i_req_1 && w_cls_1 == LDST;
  assign w_el_2 = i_req_2 && w_cls_2 == ARITH;
  // r_rr set means port 2 has priority on a tie
  assign w_g2   = w_el_2 && (!w_el_1 || r_rr);
  assign w_greq = r_sel ? i_req_2 : i_req_1;
  assign w_tmo  = r_cnt == 8'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rr          <= 1'b0;
      r_ack_1       <= 1'b0;
      r_ack_2       <= 1'b0;
      r_alu_req     <= 1'b0;
      r_sel         <= 1'b0;
      r_op          <= '0;
      r_opc_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((i_req_1 && !w_el_1) || (i_req_2 && !w_el_2)) r_opc_err <= 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_el_1 || w_el_2) begin
            r_state   <= ALU_REQ;
            r_alu_req <= 1'b1;
            r_sel     <= w_g2;
            r_op      <= w_g2 ? i_opcode_2 : i_opcode_1;
            r_rr      <= !w_g2;
          end
        end
        ACK_UP: begin
          r_cnt <= '0;
          if (!w_greq) begin
            r_state   <= ALU_REL;
            r_alu_req <= 1'b0;
          end
        end
        default: begin
          // ALU_REQ waits for ack rise, ALU_REL for ack fall; both are bounded by TIMEOUT
          if (r_state == ALU_REQ ? i_alu_ack : !i_alu_ack) begin
            r_state <= r_state == ALU_REQ ? ACK_UP : IDLE;
            r_cnt   <= '0;
            r_ack_1 <= r_state == ALU_REQ && !r_sel;
            r_ack_2 <= r_state == ALU_REQ && r_sel;
          end else if (w_tmo) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_alu_req     <= 1'b0;
            r_ack_1       <= 1'b0;
            r_ack_2       <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign o_ack_1       = r_ack_1;
  assign o_ack_2       = r_ack_2;
  assign o_alu_req     = r_alu_req;
  assign o_alu_sel     = r_sel;
  assign o_alu_op      = r_op;
  assign o_opc_err     = r_opc_err;
  assign o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  logic       clk = 0, rst = 1;
  logic       req_1 = 0, req_2 = 0, ack_1, ack_2, alu_req, alu_ack, alu_sel, opc_err, timeout_err;
  logic [6:0] op_1 = 0, op_2 = 0, alu_op;
  logic       echo = 1, ack_drv = 0;
  int         n_chk = 0, n_pass = 0;

  assign alu_ack = echo ? alu_req : ack_drv;

  alu_share_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req_1(req_1), .i_opcode_1(op_1), .o_ack_1(ack_1),
    .i_req_2(req_2), .i_opcode_2(op_2), .o_ack_2(ack_2),
    .o_alu_req(alu_req), .i_alu_ack(alu_ack), .o_alu_sel(alu_sel), .o_alu_op(alu_op),
    .o_opc_err(opc_err), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack1"}, ack_1, 0);
    chk({tag, "_ack2"}, ack_2, 0);
    chk({tag, "_areq"}, alu_req, 0);
    chk({tag, "_sel"}, alu_sel, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_oerr"}, opc_err, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic do_txn(input int idx, input logic exp_sel);
    int t;
    t = 0;
    while (!alu_req && t < 20) begin tick(); t++; end
    chk($sformatf("rr%0d_grant", idx), alu_req, 1);
    chk($sformatf("rr%0d_sel", idx), alu_sel, exp_sel);
    chk($sformatf("rr%0d_op", idx), alu_op, exp_sel ? 8'h33 : 8'h03);
    t = 0;
    while (!(exp_sel ? ack_2 : ack_1) && t < 20) begin tick(); t++; end
    chk($sformatf("rr%0d_ack", idx), exp_sel ? ack_2 : ack_1, 1);
    chk($sformatf("rr%0d_other", idx), exp_sel ? ack_1 : ack_2, 0);
    if (exp_sel) req_2 = 0; else req_1 = 0;
    t = 0;
    while ((ack_1 || ack_2) && t < 20) begin tick(); t++; end
    chk($sformatf("rr%0d_ackfall", idx), {ack_1, ack_2}, 0);
    req_1 = 1;
    req_2 = 1;
  endtask

  initial begin
    do_reset();
    chk_reset_vals("rst");

    // basic port-1 transaction with zero-delay ALU and requester
    req_1 = 1; op_1 = 7'b0000011;
    tick();
    chk("t1_areq", alu_req, 1);
    chk("t1_sel", alu_sel, 0);
    chk("t1_op", alu_op, 8'h03);
    chk("t1_ack_c1", ack_1, 0);
    tick();
    chk("t1_ack_c2", ack_1, 1);
    req_1 = 0;
    tick();
    chk("t1_rel_areq", alu_req, 0);
    chk("t1_rel_ack", ack_1, 1);
    chk("t1_rel_op", alu_op, 8'h03);
    tick();
    chk("t1_ackfall", ack_1, 0);
    tick();
    chk("t1_idle", alu_req, 0);
    chk("t1_oerr", opc_err, 0);

    // simultaneous eligible requests alternate 1,2,1,2,...
    do_reset();
    op_1 = 7'b0000011; op_2 = 7'b0110011;
    req_1 = 1; req_2 = 1;
    for (int i = 0; i < 8; i++) do_txn(i, logic'(i % 2));
    req_1 = 0; req_2 = 0;
    tick(3);
    chk("rr_oerr", opc_err, 0);

    // wrong-class opcode on port 2
    do_reset();
    req_2 = 1; op_2 = 7'b0000011;
    tick();
    chk("oerr_set", opc_err, 1);
    chk("oerr_areq", alu_req, 0);
    chk("oerr_ack2", ack_2, 0);
    tick(3);
    chk("oerr_areq_l", alu_req, 0);
    chk("oerr_ack2_l", ack_2, 0);
    req_2 = 0;
    tick();
    chk("oerr_sticky", opc_err, 1);

    // ALU never acknowledges
    do_reset();
    echo = 0; ack_drv = 0;
    req_1 = 1; op_1 = 7'b0100011;
    tick();
    chk("to_grant", alu_req, 1);
    chk("to_op", alu_op, 8'h23);
    tick(15);
    chk("to_not_yet", timeout_err, 0);
    chk("to_areq_held", alu_req, 1);
    tick();
    chk("to_set", timeout_err, 1);
    chk("to_areq", alu_req, 0);
    chk("to_ack1", ack_1, 0);
    req_1 = 0;
    tick(2);
    chk("to_idle", alu_req, 0);
    chk("to_sticky", timeout_err, 1);

    // asynchronous reset while in ACK_UP
    echo = 1;
    do_reset();
    req_1 = 1; op_1 = 7'b0000011;
    tick(2);
    chk("ar_ackup", ack_1, 1);
    chk("ar_areq", alu_req, 1);
    #2 rst = 1;
    #1 chk_reset_vals("ar");
    req_1 = 0;
    tick();
    rst = 0;
    tick(2);
    chk("ar_post", alu_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
